// File: rtl/uart_wb_dbg_pkg.sv
// Shared definitions for the UART-to-Wishbone debug bridge.
// Holds host command codes, frame/word byte-count constants and the
// state encodings used by the bridge FSM and the UART receiver.
package uart_wb_dbg_pkg;

    // Host command bytes
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    // Address and data words are both 4 bytes on the wire
    localparam int unsigned WORD_BYTES = 4;
    localparam logic [1:0]  LAST_BYTE  = 2'(WORD_BYTES - 1);

    // 8N1: start + 8 data + stop
    localparam int unsigned UART_FRAME_BITS = 10;

    typedef enum logic [2:0] {
        StIdle,
        StSize,
        StAddr,
        StWdata,
        StWbWr,
        StWbRd,
        StRdata,
        StNext
    } state_e;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

endpackage

// File: rtl/uart_wb_dbg_phy.sv
// UART physical layer for the debug bridge: 2-flop input synchroniser,
// mid-bit RX sampler with start-glitch rejection, and an 8N1 TX serialiser.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   rx_i                  raw serial input (asynchronous, idle high)
//   tx_o                  serial output (registered, idle high)
//   rx_data_o/rx_valid_o  received byte with 1-cycle valid pulse
//   rx_ferr_o             1-cycle pulse when a byte has a 0 stop bit
//   tx_data_i/tx_start_i  byte to send, loaded on tx_start_i when idle
//   tx_busy_o             high for exactly UART_FRAME_BITS*CLK_DIV cycles
module uart_wb_dbg_phy
    import uart_wb_dbg_pkg::*;
#(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       tx_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_ferr_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_start_i,
    output logic       tx_busy_o
);

    localparam int unsigned   CW             = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST       = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST      = CW'(CLK_DIV / 2 - 1);
    localparam logic [3:0]    LAST_FRAME_BIT = 4'(UART_FRAME_BITS - 1);

    logic          rx_meta_q;
    logic          rx_sync_q;
    logic          rx_prev_q;
    rx_state_e     rx_state_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;

    logic [9:0]    tx_shift_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;

    // Receiver
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            rx_ferr_o  <= 1'b0;
        end else begin
            rx_meta_q  <= rx_i;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_valid_o <= 1'b0;
            rx_ferr_o  <= 1'b0;
            case (rx_state_q)
                RxIdle: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RxStart;
                        rx_cnt_q   <= '0;
                    end
                end
                RxStart: begin
                    // Line back high at mid start bit means it was a glitch
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_sync_q ? RxIdle : RxData;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                RxData: begin
                    if (rx_cnt_q == DIV_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RxStop;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                RxStop: begin
                    if (rx_cnt_q == DIV_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RxIdle;
                        if (rx_sync_q) begin
                            rx_data_o  <= rx_shift_q;
                            rx_valid_o <= 1'b1;
                        end else begin
                            rx_ferr_o <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    // Transmitter: shift register idles at all ones so tx_o rests high
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_shift_q <= '1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_busy_o  <= 1'b0;
        end else if (!tx_busy_o) begin
            if (tx_start_i) begin
                tx_shift_q <= {1'b1, tx_data_i, 1'b0};
                tx_cnt_q   <= '0;
                tx_bit_q   <= '0;
                tx_busy_o  <= 1'b1;
            end
        end else if (tx_cnt_q == DIV_LAST) begin
            tx_cnt_q   <= '0;
            tx_shift_q <= {1'b1, tx_shift_q[9:1]};
            if (tx_bit_q == LAST_FRAME_BIT) begin
                tx_busy_o <= 1'b0;
            end else begin
                tx_bit_q <= tx_bit_q + 4'd1;
            end
        end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
        end
    end

    assign tx_o = tx_shift_q[0];

endmodule

// File: rtl/uart_wb_debug_bridge.sv
// UART-to-Wishbone debug master. Host protocol over 8N1 UART:
//   cmd (01 write / 02 read), size (word count), 4 address bytes MSB first,
//   then for writes 4 data bytes LSB first per word. Reads return 4 bytes
//   LSB first per word. Burst words advance the address by ADDR_STEP.
// Optional feature macro: WB_TIMEOUT_EN -- abort a bus cycle after
//   TIMEOUT_CYCLES without ack, set err_o, cancel the rest of the burst and
//   return 0xFFFFFFFF for an aborted read.
// Ports:
//   wb_clk_i, wb_rst_i    clock, synchronous active-high reset
//   uart_rx, uart_tx      serial in (async, idle high) / serial out
//   wbm_*                 Wishbone classic master (32-bit, sel always F)
//   busy_o                high whenever the FSM is not idle
//   err_o                 sticky framing/timeout error, cleared by reset
module uart_wb_debug_bridge
    import uart_wb_dbg_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 434,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ADDR_STEP      = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy_o,
    output logic        err_o
);

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ferr;
    logic        tx_busy;

    state_e      state_q;
    logic        is_read_q;
    logic [7:0]  count_q;
    logic [1:0]  idx_q;
    logic [31:0] rdata_q;
    logic [7:0]  tx_data_q;
    logic        tx_start_q;

`ifdef WB_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    uart_wb_dbg_phy #(
        .CLK_DIV (CLK_DIV)
    ) u_phy (
        .clk_i      (wb_clk_i),
        .rst_i      (wb_rst_i),
        .rx_i       (uart_rx),
        .tx_o       (uart_tx),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .rx_ferr_o  (rx_ferr),
        .tx_data_i  (tx_data_q),
        .tx_start_i (tx_start_q),
        .tx_busy_o  (tx_busy)
    );

    assign busy_o = (state_q != StIdle);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= StIdle;
            is_read_q  <= 1'b0;
            count_q    <= '0;
            idx_q      <= '0;
            rdata_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_sel_o  <= '0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
            err_o      <= 1'b0;
`ifdef WB_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            tx_start_q <= 1'b0;
`ifdef WB_TIMEOUT_EN
            if (state_q != StWbWr && state_q != StWbRd) begin
                tmo_q <= '0;
            end
`endif
            case (state_q)
                StIdle: begin
                    if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                        is_read_q <= (rx_data == CMD_READ);
                        state_q   <= StSize;
                    end
                end
                StSize: begin
                    if (rx_valid) begin
                        count_q <= rx_data;
                        idx_q   <= '0;
                        state_q <= (rx_data == 8'd0) ? StIdle : StAddr;
                    end
                end
                StAddr: begin
                    if (rx_valid) begin
                        wbm_adr_o <= {wbm_adr_o[23:0], rx_data};
                        idx_q     <= idx_q + 2'd1;
                        if (idx_q == LAST_BYTE) begin
                            idx_q <= '0;
                            if (is_read_q) begin
                                wbm_cyc_o <= 1'b1;
                                wbm_stb_o <= 1'b1;
                                wbm_we_o  <= 1'b0;
                                wbm_sel_o <= 4'hF;
                                state_q   <= StWbRd;
                            end else begin
                                state_q <= StWdata;
                            end
                        end
                    end
                end
                StWdata: begin
                    // Bytes arrive LSB first: shift in from the top
                    if (rx_valid) begin
                        wbm_dat_o <= {rx_data, wbm_dat_o[31:8]};
                        idx_q     <= idx_q + 2'd1;
                        if (idx_q == LAST_BYTE) begin
                            idx_q     <= '0;
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_we_o  <= 1'b1;
                            wbm_sel_o <= 4'hF;
                            state_q   <= StWbWr;
                        end
                    end
                end
                StWbWr, StWbRd: begin
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= '0;
                        if (state_q == StWbRd) begin
                            rdata_q    <= wbm_dat_i;
                            tx_data_q  <= wbm_dat_i[7:0];
                            tx_start_q <= 1'b1;
                            idx_q      <= '0;
                            state_q    <= StRdata;
                        end else begin
                            state_q <= StNext;
                        end
                    end
`ifdef WB_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= '0;
                        err_o     <= 1'b1;
                        // Zero count marks the burst as cancelled
                        count_q   <= '0;
                        if (state_q == StWbRd) begin
                            rdata_q    <= '1;
                            tx_data_q  <= 8'hFF;
                            tx_start_q <= 1'b1;
                            idx_q      <= '0;
                            state_q    <= StRdata;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
`endif
                end
                StRdata: begin
                    // tx_busy only rises the cycle after tx_start, so skip that cycle
                    if (!tx_start_q && !tx_busy) begin
                        if (idx_q == LAST_BYTE) begin
                            state_q <= (count_q == 8'd0) ? StIdle : StNext;
                        end else begin
                            idx_q      <= idx_q + 2'd1;
                            rdata_q    <= {8'h00, rdata_q[31:8]};
                            tx_data_q  <= rdata_q[15:8];
                            tx_start_q <= 1'b1;
                        end
                    end
                end
                StNext: begin
                    wbm_adr_o <= wbm_adr_o + 32'(ADDR_STEP);
                    count_q   <= count_q - 8'd1;
                    idx_q     <= '0;
                    if (count_q == 8'd1) begin
                        state_q <= StIdle;
                    end else if (is_read_q) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= 4'hF;
                        state_q   <= StWbRd;
                    end else begin
                        state_q <= StWdata;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Framing error aborts header/data collection; bus phases run on
            if (rx_ferr) begin
                err_o <= 1'b1;
                if (state_q == StSize || state_q == StAddr || state_q == StWdata) begin
                    state_q <= StIdle;
                end
            end
        end
    end

endmodule

// File: doc/uart_wb_debug_bridge.md
Name: uart_wb_debug_bridge

Overview:
Synthesizable UART-to-Wishbone debug master for the management SoC. It replaces the simulation-only UART command driver with real RTL. It accepts the host byte protocol over an 8N1 UART: cmd, size, 4 address bytes MSB-first, then per-word data bytes LSB-first. It issues single or burst 32-bit Wishbone classic cycles and returns read data over UART TX.

Parameters:
CLK_DIV, 434, wb_clk_i cycles per UART bit (≥4); 434 gives 115200 baud at 50 MHz
TIMEOUT_CYCLES, 1024, ack wait limit; used only when WB_TIMEOUT_EN is defined
ADDR_STEP, 4, byte increment applied to address after each burst word

Ports:
wb_clk_i  input  1  system clock
wb_rst_i  input  1  synchronous reset, active high
uart_rx  input  1  serial in, idle high, asynchronous to wb_clk_i
uart_tx  output  1  serial out, idle high
wbm_cyc_o  output  1  Wishbone cycle
wbm_stb_o  output  1  Wishbone strobe
wbm_we_o  output  1  write enable
wbm_sel_o  output  4  byte selects, always 4'hF during a cycle
wbm_adr_o  output  32  byte address
wbm_dat_o  output  32  write data
wbm_dat_i  input  32  read data
wbm_ack_i  input  1  acknowledge
busy_o  output  1  high in any state other than IDLE
err_o  output  1  sticky error flag

Behaviour:
- Reset: uart_tx=1; cyc/stb/we=0; sel=0; adr=0; dat_o=0; busy_o=0; err_o=0; FSM enters IDLE; rx/tx shifters are cleared.
- Reset mid-operation: any cycle in progress is dropped on the next edge. No partial UART byte completes. Reset wins over a simultaneous ack.
- RX path:
  - 2-flop synchroniser on uart_rx.
  - A start bit is detected on a high-to-low transition and re-checked at CLK_DIV/2. If it is high at that point, it is a glitch and is ignored.
  - Data bits are sampled every CLK_DIV cycles after that.
  - Stop bit must be 1. If it is 0 (framing error), the byte is discarded, err_o is set, and the FSM returns to IDLE.
  - A valid byte produces a 1-cycle rx_valid pulse.
- TX path: 8N1. A tx_start pulse loads the byte. tx_busy is held for 10*CLK_DIV cycles. There is no extra stop padding.
- Commands: 0x01 = write, 0x02 = read. Any other byte received in IDLE is discarded and the FSM stays in IDLE.
- FSM states:
  - IDLE: wait for a command byte.
  - SIZE: size byte → count. Size 0 returns to IDLE with no bus activity.
  - ADDR: 4 bytes, MSB first, shifted into adr.
  - Then WDATA for writes, or WB_RD for reads.
  - WDATA: 4 bytes, LSB first, into dat_o. Then WB_WR.
  - WB_WR / WB_RD:
    - Assert cyc=stb=1, we=1 for WB_WR and 0 for WB_RD, sel=F.
    - Hold until wbm_ack_i.
    - cyc/stb drop on the clock edge after ack is sampled.
    - Read data is captured on ack.
  - RDATA: send the 4 captured bytes LSB first, back-to-back, each started when tx_busy falls.
  - NEXT: adr += ADDR_STEP (mod 2^32, wraps 0xFFFFFFFC→0). count -= 1. Go to IDLE if count==0, otherwise WDATA or WB_RD.
- RX bytes arriving in WB_RD, WB_WR, RDATA or NEXT are discarded.
- Bus latency: stb rises 1 cycle after the final address/data byte's rx_valid.
- err_o clears only on reset.

Optional Feature:
WB_TIMEOUT_EN:
- Defined:
  - A counter starts when stb rises. It aborts if TIMEOUT_CYCLES elapse without ack.
  - On abort: cyc/stb drop, err_o is set, and the rest of the burst is cancelled.
  - For reads, the aborted word is returned as 0xFFFFFFFF (4 bytes 0xFF) before the FSM enters IDLE.
- Undefined: the bridge waits indefinitely for ack. There is no counter logic, and err_o reflects framing errors only.

Decomposition:
- Package uart_wb_dbg_pkg: command codes (CMD_WRITE=8'h01, CMD_READ=8'h02), FSM state encoding, byte-count constants.
- One sub-module, uart_wb_dbg_phy: synchroniser, RX sampler and TX serialiser, parametrised by CLK_DIV, exposing rx_data/rx_valid/rx_ferr/tx_data/tx_start/tx_busy.

Test Plan:
- CLK_DIV=8. Send 01 01 01 00 00 94 ab 55 55 77 → one write cycle, adr=0x01000094, dat_o=0x775555ab, sel=F, we=1; busy_o falls after ack.
- Send 02 01 01 00 00 94; slave returns 0x775555ab → uart_tx emits ab,55,55,77 in order; cyc low 1 cycle after ack.
- Read burst size 3 at 0xFFFFFFF8 → adr sequence FFFFFFF8, FFFFFFFC, 00000000; 12 TX bytes.
- Send 0x55, then a byte with stop bit 0 → 0x55 ignored, err_o=1 after the bad byte; a following valid write completes normally.
- Assert wb_rst_i while stb is high mid-burst → next edge cyc=stb=0, uart_tx=1, busy_o=0; a new command is then accepted.
- WB_TIMEOUT_EN, TIMEOUT_CYCLES=16, read with no ack → stb drops after 16 cycles, err_o=1, TX ff ff ff ff, rest of burst skipped.
